// File: rtl/sw_pattern_recorder_pkg.sv
// Shared constants and FSM encoding for the switch pattern recorder.
// The blink-pattern player takes its slot timing from the same defaults.
package sw_pattern_recorder_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RECORD = 1'b1
  } rec_state_t;

  // Slot period is 2^DEF_SLOT_W cycles, matching the player's counter[25:21].
  localparam int DEF_SLOT_W       = 21;
  localparam int DEF_PATTERN_LEN  = 32;
  // 3 ms of stable input at 16 MHz.
  localparam int DEF_DEBOUNCE_MAX = 48000;

endpackage

// File: rtl/sw_pattern_recorder_debounce.sv
// Single-bit switch conditioner: two-flop synchronizer, debounce counter
// and registered rising-edge detect on the debounced level.
module sw_pattern_recorder_debounce
  import sw_pattern_recorder_pkg::*;
#(
  parameter int DEBOUNCE_MAX = DEF_DEBOUNCE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_MAX + 1);

  logic             sync1;
  logic             sync2;
  logic             db_d;
  logic [CNT_W-1:0] cnt;

  // Synchronize, count cycles of disagreement, follow once it persists,
  // and flag the cycle after the debounced level rises.
  // A change sampled at edge E reaches db at edge E+DEBOUNCE_MAX+2; any
  // agreement in between (a bounce) clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      db_d  <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples the
      // pre-edge value of the others; blocking ones would collapse the
      // synchronizer chain into a single stage.
      sync1 <= sw;
      sync2 <= sync1;
      db_d  <= db;
      rise  <= db & ~db_d;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_MAX)) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_pattern_recorder.sv
// Debounces the board switches and records a PATTERN_LEN-slot blink
// pattern from the data switch, armed by a rising edge on the arm switch.
// Bit i of PATTERN is the data switch level at the end of slot i.
module sw_pattern_recorder
  import sw_pattern_recorder_pkg::*;
#(
  parameter int NUM_SW       = 4,
  parameter int DEBOUNCE_MAX = DEF_DEBOUNCE_MAX,
  parameter int SLOT_W       = DEF_SLOT_W,
  parameter int PATTERN_LEN  = DEF_PATTERN_LEN,
  parameter int DATA_IDX     = 0,
  parameter int ARM_IDX      = 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_SW-1:0]              SW,
  output logic [NUM_SW-1:0]              SW_DB,
  output logic [NUM_SW-1:0]              SW_RISE,
  output logic [PATTERN_LEN-1:0]         PATTERN,
  output logic                           PATTERN_VALID,
  output logic                           RECORDING,
  output logic                           DONE,
  output logic [$clog2(PATTERN_LEN)-1:0] SLOT_IDX
);

  localparam int IDX_W = $clog2(PATTERN_LEN);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    sw_pattern_recorder_debounce #(
      .DEBOUNCE_MAX(DEBOUNCE_MAX)
    ) u_debounce (
      .clk  (CLK),
      .rst  (RST),
      .sw   (SW[i]),
      .db   (SW_DB[i]),
      .rise (SW_RISE[i])
    );
  end

  rec_state_t             state;
  rec_state_t             state_next;
  logic [SLOT_W-1:0]      slot_cnt;
  logic [SLOT_W-1:0]      cnt_next;
  logic [IDX_W-1:0]       idx_next;
  logic [PATTERN_LEN-1:0] buffer;
  logic [PATTERN_LEN-1:0] buf_next;
  logic [PATTERN_LEN-1:0] sampled;
  logic [PATTERN_LEN-1:0] pat_next;
  logic                   valid_next;
  logic                   done_next;
  logic                   arm;
  logic                   terminal;
  logic                   final_slot;

  assign arm        = SW_RISE[ARM_IDX];
  assign terminal   = (slot_cnt == '1);
  assign final_slot = (SLOT_IDX == IDX_W'(PATTERN_LEN - 1));
  assign RECORDING  = (state == ST_RECORD);

  // Capture buffer as it would look with the current slot's bit stored.
  always_comb begin
    sampled           = buffer;
    sampled[SLOT_IDX] = SW_DB[DATA_IDX];
  end

  // Next-state logic: completion of the final slot outranks a coincident
  // arm edge; otherwise an arm edge (re)starts a clean recording.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_next = state;
    cnt_next   = slot_cnt;
    idx_next   = SLOT_IDX;
    buf_next   = buffer;
    pat_next   = PATTERN;
    valid_next = PATTERN_VALID;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          state_next = ST_RECORD;
          cnt_next   = '0;
          idx_next   = '0;
          buf_next   = '0;
        end
      end
      ST_RECORD: begin
        if (terminal && final_slot) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          idx_next   = '0;
          buf_next   = sampled;
          pat_next   = sampled;
          valid_next = 1'b1;
          done_next  = 1'b1;
        end else if (arm) begin
          cnt_next = '0;
          idx_next = '0;
          buf_next = '0;
        end else begin
          cnt_next = slot_cnt + SLOT_W'(1);
          if (terminal) begin
            buf_next = sampled;
            idx_next = SLOT_IDX + IDX_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any result as well.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the capture buffer and PATTERN are ordinary flops and are
      // cleared here too, so a reset never leaves a stale pattern behind.
      state         <= ST_IDLE;
      slot_cnt      <= '0;
      SLOT_IDX      <= '0;
      buffer        <= '0;
      PATTERN       <= '0;
      PATTERN_VALID <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      state         <= state_next;
      slot_cnt      <= cnt_next;
      SLOT_IDX      <= idx_next;
      buffer        <= buf_next;
      PATTERN       <= pat_next;
      PATTERN_VALID <= valid_next;
      DONE          <= done_next;
    end
  end

endmodule

// File: tb/tb_sw_pattern_recorder.sv
// Bench for sw_pattern_recorder at small timing parameters: a debounce
// vector table, hand-written recording scenarios and a randomized run,
// all shadowed cycle by cycle by a behavioural model.
module tb_sw_pattern_recorder;

  localparam int NUM_SW   = 4;
  localparam int DB_MAX   = 4;
  localparam int SLOT_W   = 3;
  localparam int PLEN     = 8;
  localparam int SLOT_CYC = 1 << SLOT_W;
  localparam int TOTAL    = PLEN * SLOT_CYC;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_SW-1:0] sw;
  logic [NUM_SW-1:0] sw_db;
  logic [NUM_SW-1:0] sw_rise;
  logic [PLEN-1:0]   pattern;
  logic              pattern_valid;
  logic              recording;
  logic              done;
  logic [2:0]        slot_idx;

  sw_pattern_recorder #(
    .NUM_SW       (NUM_SW),
    .DEBOUNCE_MAX (DB_MAX),
    .SLOT_W       (SLOT_W),
    .PATTERN_LEN  (PLEN),
    .DATA_IDX     (0),
    .ARM_IDX      (1)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .SW            (sw),
    .SW_DB         (sw_db),
    .SW_RISE       (sw_rise),
    .PATTERN       (pattern),
    .PATTERN_VALID (pattern_valid),
    .RECORDING     (recording),
    .DONE          (done),
    .SLOT_IDX      (slot_idx)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int rec_cycles = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce: the comparator sees the input sampled two edges earlier; the
  // level flips once the last DB_MAX+1 comparator views all disagree with it.
  // Recorder: tracks the edge at which recording began and derives slot,
  // terminal cycle and completion from elapsed-cycle arithmetic.
  logic [NUM_SW-1:0] sw_q[$];
  logic [NUM_SW-1:0] cmp_q[$];
  logic [NUM_SW-1:0] m_db, m_db_d, m_rise;
  logic [PLEN-1:0]   m_bits, m_pat;
  logic              m_rec, m_valid, m_done;
  int                edge_n = 0;
  int                m_start = 0;

  task automatic model_edge();
    logic [NUM_SW-1:0] seen;
    logic arm, dat;
    int k;
    edge_n++;
    if (rst) begin
      sw_q.delete();
      cmp_q.delete();
      repeat (2) sw_q.push_front('0);
      repeat (DB_MAX + 1) cmp_q.push_front('0);
      m_db = '0; m_db_d = '0; m_rise = '0;
      m_bits = '0; m_pat = '0;
      m_rec = 1'b0; m_valid = 1'b0; m_done = 1'b0;
    end else begin
      arm  = m_rise[1];
      dat  = m_db[0];
      seen = sw_q[1];
      sw_q.push_front(sw);
      void'(sw_q.pop_back());
      cmp_q.push_front(seen);
      void'(cmp_q.pop_back());
      m_rise = m_db & ~m_db_d;
      m_db_d = m_db;
      for (int b = 0; b < NUM_SW; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        foreach (cmp_q[j]) if (cmp_q[j][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) m_db[b] = ~m_db[b];
      end
      m_done = 1'b0;
      if (m_rec) begin
        k = edge_n - m_start - 1;
        if (k % SLOT_CYC == SLOT_CYC - 1) m_bits[k / SLOT_CYC] = dat;
        if (k == TOTAL - 1) begin
          m_pat = m_bits; m_valid = 1'b1; m_done = 1'b1; m_rec = 1'b0;
        end else if (arm) begin
          m_start = edge_n; m_bits = '0;
        end
      end else if (arm) begin
        m_rec = 1'b1; m_start = edge_n; m_bits = '0;
      end
    end
  endtask

  function automatic logic [31:0] exp_pack();
    logic [2:0] idx;
    idx = m_rec ? 3'((edge_n - m_start) / SLOT_CYC) : 3'd0;
    return 32'({m_db, m_rise, m_pat, m_valid, m_rec, m_done, idx});
  endfunction

  function automatic logic [31:0] act_pack();
    return 32'({sw_db, sw_rise, pattern, pattern_valid, recording, done, slot_idx});
  endfunction

  // One clock per iteration: model follows the edge, outputs compared on
  // the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("model", act_pack(), exp_pack());
      rec_cycles += int'(recording);
      done_count += int'(done);
    end
  endtask

  // ---------------- debounce vector table ----------------
  typedef struct {
    logic sw0;
    logic db0;
    logic rise0;
  } vec_t;

  vec_t vecs[22];
  logic [PLEN-1:0] data_a = 8'b0100_1101;
  int hold[NUM_SW];

  initial begin
    // SW[0] toggles every 2 cycles for 12 cycles, then holds 1. The last
    // change is sampled at row 12, so SW_DB[0] rises at row 18 and
    // SW_RISE[0] pulses on row 19 only.
    for (int i = 0; i < 22; i++) begin
      vecs[i].sw0   = (i < 12) ? (((i / 2) % 2) == 0) : 1'b1;
      vecs[i].db0   = (i >= 18);
      vecs[i].rise0 = (i == 19);
    end

    rst = 1'b1;
    sw  = '0;
    tick(2);
    check("reset_state", act_pack(), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      sw[0] = vecs[i].sw0;
      tick(1);
      check($sformatf("deb_db0_row%0d", i), 32'(sw_db[0]), 32'(vecs[i].db0));
      check($sformatf("deb_rise0_row%0d", i), 32'(sw_rise[0]), 32'(vecs[i].rise0));
    end

    // Recording of 1,0,1,1,0,0,1,0 (slot 0 first). Arm sampled at edge A,
    // recording runs after edges A+8..A+71, PATTERN updates at A+72.
    rec_cycles = 0;
    done_count = 0;
    sw[1] = 1'b1;
    tick(4);
    for (int s = 0; s < PLEN; s++) begin
      sw[0] = data_a[s];
      tick(SLOT_CYC);
    end
    tick(4);
    check("rec_pattern_before_end", 32'(pattern), 32'h0);
    check("rec_still_recording", 32'(recording), 32'h1);
    tick(1);
    check("rec_pattern", 32'(pattern), 32'h4D);
    check("rec_done_pulse", 32'(done), 32'h1);
    check("rec_valid", 32'(pattern_valid), 32'h1);
    check("rec_idle", 32'(recording), 32'h0);
    check("rec_slot_idx_zero", 32'(slot_idx), 32'h0);
    check("rec_cycles", 32'(rec_cycles), 32'd64);
    tick(2);
    check("rec_done_once", 32'(done_count), 32'd1);

    // Arm held high: no retrigger.
    rec_cycles = 0;
    done_count = 0;
    tick(200);
    check("hold_no_record", 32'(rec_cycles), 32'd0);
    check("hold_no_done", 32'(done_count), 32'd0);
    check("hold_pattern", 32'(pattern), 32'h4D);

    // Re-arm during slot 5 with the data switch held at 1.
    sw[1] = 1'b0;
    sw[0] = 1'b1;
    tick(10);
    sw[1] = 1'b1;
    tick(8);
    check("rearm_first_rise", 32'(sw_rise[1]), 32'h1);
    tick(1);
    check("rearm_started", 32'(recording), 32'h1);
    sw[1] = 1'b0;
    tick(35);
    sw[1] = 1'b1;
    done_count = 0;
    tick(8);
    check("rearm_in_slot5", 32'(slot_idx), 32'd5);
    check("rearm_rise", 32'(sw_rise[1]), 32'h1);
    tick(1);
    check("rearm_slot_reset", 32'(slot_idx), 32'd0);
    check("rearm_recording", 32'(recording), 32'h1);
    check("rearm_pattern_kept", 32'(pattern), 32'h4D);
    tick(63);
    check("rearm_pattern_kept_late", 32'(pattern), 32'h4D);
    check("rearm_no_done", 32'(done_count), 32'd0);
    tick(1);
    check("rearm_new_pattern", 32'(pattern), 32'hFF);
    check("rearm_done", 32'(done), 32'h1);

    // Reset during slot 3 of a recording that follows a completed one.
    sw[1] = 1'b0;
    tick(10);
    sw[1] = 1'b1;
    tick(8);
    sw[1] = 1'b0;
    tick(27);
    check("rst_in_slot3", 32'(slot_idx), 32'd3);
    check("rst_valid_before", 32'(pattern_valid), 32'h1);
    rst = 1'b1;
    tick(1);
    check("rst_all_outputs", act_pack(), 32'h0);
    rst = 1'b0;
    tick(1);
    check("rst_idle", 32'(recording), 32'h0);

    // Arm edge coincident with the final-slot terminal cycle.
    tick(10);
    sw[1] = 1'b1;
    tick(8);
    tick(1);
    check("coin_started", 32'(recording), 32'h1);
    sw[1] = 1'b0;
    tick(55);
    sw[1] = 1'b1;
    tick(8);
    check("coin_rise", 32'(sw_rise[1]), 32'h1);
    check("coin_final_slot", 32'(slot_idx), 32'd7);
    tick(1);
    check("coin_pattern", 32'(pattern), 32'hFF);
    check("coin_done", 32'(done), 32'h1);
    check("coin_valid", 32'(pattern_valid), 32'h1);
    check("coin_idle", 32'(recording), 32'h0);
    rec_cycles = 0;
    tick(20);
    check("coin_arm_ignored", 32'(rec_cycles), 32'd0);

    // Randomized run: per-switch random levels held for random lengths
    // (long holds on the arm switch so recordings can finish), rare resets.
    for (int b = 0; b < NUM_SW; b++) hold[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NUM_SW; b++) begin
        if (hold[b] == 0) begin
          sw[b]   = 1'($urandom_range(0, 1));
          hold[b] = (b == 1) ? int'($urandom_range(1, 150)) : int'($urandom_range(1, 12));
        end else begin
          hold[b]--;
        end
      end
      rst = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
